// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM encodings, stall levels, owner codes.
package mem_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_BUSY_IF  = 3'd1,
      ST_BUSY_MEM = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_RESP     = 3'd4
   } arb_state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   function automatic int unsigned cnt_width(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// External memory bus: registered request/payload out, single-cycle ack with read data back.
interface mem_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            req;
   logic            we;
   logic [DW/8-1:0] sel;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic [DW-1:0]   rdata;
   logic            ack;

   modport master (output req, we, sel, addr, wdata, input rdata, ack);
   modport slave  (input req, we, sel, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_bus_arbiter_bus_wait_timer.sv
// Counts bus wait cycles; expired is asserted combinationally on the cycle whose
// increment would bring the count to TIMEOUT, so the owner can abort on that edge.
module bus_wait_timer
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned CW = cnt_width(TIMEOUT);

   logic [CW-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (clear) begin
         wait_cnt <= '0;
      end else if (enable && (wait_cnt != CW'(TIMEOUT))) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign expired = enable && (wait_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between IF and MEM (MEM wins); grant->done is 2 cycles minimum.
// Requesters stall until their done pulse; a bus that never acks is aborted after TIMEOUT cycles.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int          AW      = 32,
   parameter int          DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              if_req,
   input  logic [AW-1:0]     if_addr,
   output logic [DW-1:0]     if_rdata,
   output logic              if_done,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [DW/8-1:0]   mem_sel,
   input  logic [AW-1:0]     mem_addr,
   input  logic [DW-1:0]     mem_wdata,
   output logic [DW-1:0]     mem_rdata,
   output logic              mem_done,
   output logic              stallreq_from_if,
   output logic              stallreq_from_mem,
   mem_bus_arbiter_if.master bus,
   output logic              bus_err
);
   arb_state_t state, state_nxt;
   owner_t     resp_own;
   logic       ack, expired, timer_clr, timer_en;
   logic       grant_mem, grant_if, resp_go, time_out;

   assign ack       = bus.ack & bus.req;
   assign timer_clr = (state == ST_IDLE) && (mem_req || (if_req && !flush));
   assign timer_en  = ((state == ST_BUSY_IF) || (state == ST_BUSY_MEM) || (state == ST_DRAIN)) && !ack;

   bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clr),
      .enable  (timer_en),
      .expired (expired)
   );

   always_comb begin
      state_nxt = state;
      grant_mem = 1'b0;
      grant_if  = 1'b0;
      resp_go   = 1'b0;
      resp_own  = OWN_IF;
      time_out  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (mem_req) begin
               grant_mem = 1'b1;
               state_nxt = ST_BUSY_MEM;
            end else if (if_req && !flush) begin
               grant_if  = 1'b1;
               state_nxt = ST_BUSY_IF;
            end
         end
         ST_BUSY_MEM: begin
            resp_own = OWN_MEM;
            if (ack || expired) begin
               resp_go   = 1'b1;
               time_out  = !ack;
               state_nxt = ST_RESP;
            end
         end
         ST_BUSY_IF: begin
            // A flushed fetch never reports done, even if its data arrives that same cycle.
            if (ack || expired) begin
               time_out  = !ack;
               resp_go   = !flush;
               state_nxt = flush ? ST_IDLE : ST_RESP;
            end else if (flush) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (ack || expired) begin
               time_out  = !ack;
               state_nxt = ST_IDLE;
            end
         end
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         bus.req   <= 1'b0;
         bus.we    <= 1'b0;
         bus.sel   <= '0;
         bus.addr  <= '0;
         bus.wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         if_done   <= 1'b0;
         mem_done  <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         if_done  <= resp_go && (resp_own == OWN_IF);
         mem_done <= resp_go && (resp_own == OWN_MEM);
         if (grant_mem) begin
            bus.req   <= 1'b1;
            bus.we    <= mem_we;
            bus.sel   <= mem_sel;
            bus.addr  <= mem_addr;
            bus.wdata <= mem_wdata;
         end else if (grant_if) begin
            bus.req   <= 1'b1;
            bus.we    <= 1'b0;
            bus.sel   <= '1;
            bus.addr  <= if_addr;
            bus.wdata <= '0;
         end else if (ack || time_out) begin
            bus.req <= 1'b0;
         end
         if (time_out) begin
            bus_err <= 1'b1;
         end
         if (resp_go && (resp_own == OWN_IF)) begin
            if_rdata <= time_out ? '0 : bus.rdata;
         end
         if (resp_go && (resp_own == OWN_MEM)) begin
            mem_rdata <= time_out ? '0 : bus.rdata;
         end
      end
   end

   assign stallreq_from_if  = (if_req && !if_done && !flush) ? STOP : NO_STOP;
   assign stallreq_from_mem = (mem_req && !mem_done) ? STOP : NO_STOP;

endmodule
